// File: rtl/idma_axi_w_beat_gen_if.sv
// AXI W-channel bundle between the iDMA write beat generator (master) and the write manager (slave).
interface idma_axi_w_beat_gen_if #(
    parameter int unsigned DataWidth = 16
) ();
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic [DataWidth-1:0] w_data;
    logic [StrbWidth-1:0] w_strb;
    logic                 w_last;
    logic                 w_valid;
    logic                 w_ready;

    modport master (
        output w_data, w_strb, w_last, w_valid,
        input  w_ready
    );

    modport slave (
        input  w_data, w_strb, w_last, w_valid,
        output w_ready
    );
endinterface

// File: rtl/idma_axi_w_beat_gen.sv
// Expands legalized write-burst descriptors into AXI W beats (strobes, last, burst-done pulse).
// Optional 2-entry output skid slice: define IDMA_W_BEAT_GEN_SKID_EN.
module idma_axi_w_beat_gen #(
    parameter  int unsigned DataWidth   = 16,
    parameter  int unsigned LenWidth    = 8,
    localparam int unsigned StrbWidth   = DataWidth / 8,
    localparam int unsigned OffsetWidth = $clog2(StrbWidth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [OffsetWidth-1:0] req_offset_i,
    input  logic [OffsetWidth-1:0] req_tailer_i,
    input  logic [LenWidth-1:0]    req_num_beats_i,
    input  logic                   req_is_single_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [DataWidth-1:0]   buf_data_i,
    input  logic                   buf_valid_i,
    output logic                   buf_ready_o,
    idma_axi_w_beat_gen_if.master  w,
    input  logic                   kill_i,
    output logic                   burst_done_o,
    output logic                   busy_o
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [LenWidth-1:0]    cnt_q, cnt_d;
    logic [LenWidth-1:0]    num_beats_q, num_beats_d;
    logic [OffsetWidth-1:0] offset_q, offset_d;
    logic [OffsetWidth-1:0] tailer_q, tailer_d;
    logic                   single_q, single_d;

    logic                 core_valid, core_ready, core_fire;
    logic                 is_last, last_fire, load;
    logic [StrbWidth-1:0] first_mask, last_mask, core_strb;

    // Compare happens before the increment, so num_beats = all ones needs no extra counter bit.
    assign is_last    = single_q | (cnt_q == num_beats_q);
    assign core_valid = (state_q == BURST) & buf_valid_i;
    assign core_fire  = core_valid & core_ready;
    assign last_fire  = core_fire & is_last;
    assign load       = req_valid_i & req_ready_o;

    for (genvar gi = 0; gi < StrbWidth; gi++) begin : g_mask
        localparam logic [OffsetWidth-1:0] ByteIdx = OffsetWidth'(gi);
        assign first_mask[gi] = (ByteIdx >= offset_q);
        assign last_mask[gi]  = (tailer_q == '0) || (ByteIdx < tailer_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            num_beats_q <= '0;
            offset_q    <= '0;
            tailer_q    <= '0;
            single_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num_beats_q <= num_beats_d;
            offset_q    <= offset_d;
            tailer_q    <= tailer_d;
            single_q    <= single_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        num_beats_d = num_beats_q;
        offset_d    = offset_q;
        tailer_d    = tailer_q;
        single_d    = single_q;
        if (kill_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) state_d = BURST;
                end
                BURST: begin
                    if (core_fire) begin
                        if (!is_last)   cnt_d   = cnt_q + LenWidth'(1);
                        else if (!load) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            // A descriptor taken on the last beat loads in place so bursts run back to back.
            if (load) begin
                cnt_d       = '0;
                num_beats_d = req_num_beats_i;
                offset_d    = req_offset_i;
                tailer_d    = req_tailer_i;
                single_d    = req_is_single_i;
            end
        end
    end

    always_comb begin
        req_ready_o = 1'b0;
        core_strb   = '0;
        unique case (state_q)
            IDLE:    req_ready_o = ~kill_i;
            BURST:   req_ready_o = last_fire & ~kill_i;
            default: req_ready_o = 1'b0;
        endcase
        if (core_valid) begin
            core_strb = '1;
            if (cnt_q == '0) core_strb = core_strb & first_mask;
            if (is_last)     core_strb = core_strb & last_mask;
        end
    end

    // The buffer word is popped only when it is actually accepted downstream.
    assign buf_ready_o = core_fire;

`ifdef IDMA_W_BEAT_GEN_SKID_EN
    logic [DataWidth-1:0] sk_data_q [2];
    logic [StrbWidth-1:0] sk_strb_q [2];
    logic [1:0]           sk_last_q;
    logic                 sk_wr_q, sk_rd_q;
    logic [1:0]           sk_cnt_q;
    logic                 sk_pop;

    assign sk_pop     = (sk_cnt_q != 2'd0) & w.w_ready;
    assign core_ready = (sk_cnt_q != 2'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                sk_data_q[i] <= '0;
                sk_strb_q[i] <= '0;
            end
            sk_last_q <= '0;
            sk_wr_q   <= 1'b0;
            sk_rd_q   <= 1'b0;
            sk_cnt_q  <= '0;
        end else if (kill_i) begin
            for (int i = 0; i < 2; i++) begin
                sk_data_q[i] <= '0;
                sk_strb_q[i] <= '0;
            end
            sk_last_q <= '0;
            sk_wr_q   <= 1'b0;
            sk_rd_q   <= 1'b0;
            sk_cnt_q  <= '0;
        end else begin
            // Vacated entries are zeroed so idle outputs read as 0 straight from the flops.
            if (sk_pop) begin
                sk_data_q[sk_rd_q] <= '0;
                sk_strb_q[sk_rd_q] <= '0;
                sk_last_q[sk_rd_q] <= 1'b0;
                sk_rd_q            <= ~sk_rd_q;
            end
            if (core_fire) begin
                sk_data_q[sk_wr_q] <= buf_data_i;
                sk_strb_q[sk_wr_q] <= core_strb;
                sk_last_q[sk_wr_q] <= is_last;
                sk_wr_q            <= ~sk_wr_q;
            end
            sk_cnt_q <= sk_cnt_q + {1'b0, core_fire} - {1'b0, sk_pop};
        end
    end

    assign w.w_valid    = (sk_cnt_q != 2'd0);
    assign w.w_data     = sk_data_q[sk_rd_q];
    assign w.w_strb     = sk_strb_q[sk_rd_q];
    assign w.w_last     = sk_last_q[sk_rd_q];
    assign burst_done_o = sk_pop & sk_last_q[sk_rd_q] & ~kill_i;
    assign busy_o       = (state_q == BURST) | (sk_cnt_q != 2'd0);
`else
    assign core_ready   = w.w_ready;
    assign w.w_valid    = core_valid;
    assign w.w_data     = core_valid ? buf_data_i : '0;
    assign w.w_strb     = core_strb;
    assign w.w_last     = core_valid & is_last;
    assign burst_done_o = last_fire & ~kill_i;
    assign busy_o       = (state_q == BURST);
`endif

endmodule
